vx_mem_port_arb: RTL and testbench

- Downstream neighbour of the GPU top's flattened L1 memory ports.
- Merges NPORTS request channels onto one external memory port using round-robin arbitration.
- Appends the winning port index to the tag, and routes responses back to the originating port by that index.
- Registered on both paths so timing to the memory controller/AXI adapter is isolated.

---
 rtl/vx_mem_port_arb.sv | 220 ++++++++++++++++++++++
 tb/tb_vx_mem_port_arb.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_port_arb.sv
// vx_mem_port_arb
// Merges NPORTS memory request channels onto one downstream port with a
// round-robin arbiter, extends the request tag with the winning port index
// (index in the LSBs), and steers responses back by that index.
// Both paths are registered: requests go through a 2-entry skid buffer
// (main + spill), responses through a 1-entry register with bypass-ready.
// Optional build macro: VX_MEM_ARB_PERF_EN adds 64-bit perf counters.

module vx_mem_port_arb #(
  parameter int NPORTS      = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_SIZE   = 64,
  parameter int FLAGS_WIDTH = 4,
  parameter int TAG_WIDTH   = 8,
  localparam int LG_N       = (NPORTS > 1) ? $clog2(NPORTS) : 0,
  localparam int REQ_W      = 1 + ADDR_WIDTH + DATA_SIZE*8 + DATA_SIZE + FLAGS_WIDTH + TAG_WIDTH,
  localparam int RSP_W      = DATA_SIZE*8 + TAG_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NPORTS-1:0]         in_req_valid,
  input  logic [NPORTS*REQ_W-1:0]   in_req_data,
  output logic [NPORTS-1:0]         in_req_ready,
  output logic [NPORTS-1:0]         in_rsp_valid,
  output logic [NPORTS*RSP_W-1:0]   in_rsp_data,
  input  logic [NPORTS-1:0]         in_rsp_ready,
  output logic                      out_req_valid,
  output logic [REQ_W+LG_N-1:0]     out_req_data,
  input  logic                      out_req_ready,
  input  logic                      out_rsp_valid,
  input  logic [RSP_W+LG_N-1:0]     out_rsp_data,
  output logic                      out_rsp_ready,
  output logic                      busy
`ifdef VX_MEM_ARB_PERF_EN
  ,
  output logic [63:0]               perf_req_count,
  output logic [63:0]               perf_stall_cycles,
  output logic [63:0]               perf_rsp_count
`endif
);

  // Index registers need at least one bit even when there is a single port.
  localparam int PTR_W  = (LG_N > 0) ? LG_N : 1;
  localparam int OREQ_W = REQ_W + LG_N;

  // ---------------------------------------------------------------------
  // Stage p0: round-robin arbitration over the upstream request ports
  // ---------------------------------------------------------------------
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  win_idx;
  logic              win_any;
  logic [NPORTS-1:0] grant;
  logic              req_push;
  logic [REQ_W-1:0]  sel_req;
  logic [OREQ_W-1:0] push_data;

  logic              main_vld_p1;
  logic [OREQ_W-1:0] main_data_p1;
  logic              spill_vld_p1;
  logic [OREQ_W-1:0] spill_data_p1;
  logic              req_pop;

  // Search for the first valid port starting at rr_ptr, wrapping at NPORTS.
  // With no valid port the grant parks on rr_ptr so exactly one bit is set.
  always_comb begin
    int j;
    j       = 0;
    win_idx = rr_ptr;
    win_any = 1'b0;
    for (int k = 0; k < NPORTS; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NPORTS) j = j - NPORTS;
      if (!win_any && in_req_valid[j]) begin
        win_any = 1'b1;
        win_idx = PTR_W'(j);
      end
    end
  end

  assign grant        = NPORTS'(1) << win_idx;
  assign in_req_ready = grant & {NPORTS{~spill_vld_p1 & ~reset}};
  assign req_push     = |(in_req_valid & in_req_ready);
  assign sel_req      = in_req_data[win_idx*REQ_W +: REQ_W];

  // The port index goes in the tag LSBs; a single port needs no extension.
  generate
    if (LG_N > 0) begin : g_tag_ext
      assign push_data = {sel_req, win_idx};
    end else begin : g_tag_pass
      assign push_data = sel_req;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Stage p1: request skid buffer (main drives the output, spill absorbs
  // the one request accepted while the downstream stalls)
  // ---------------------------------------------------------------------
  assign req_pop       = main_vld_p1 & out_req_ready;
  assign out_req_valid = main_vld_p1;
  assign out_req_data  = main_data_p1;

  // Occupancy and round-robin pointer; pointer advances only on a transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld_p1  <= 1'b0;
      spill_vld_p1 <= 1'b0;
      rr_ptr       <= '0;
    end else begin
      if (req_pop) begin
        // Spill full means no push this cycle (ready was masked).
        if (spill_vld_p1) begin
          main_vld_p1  <= 1'b1;
          spill_vld_p1 <= 1'b0;
        end else begin
          main_vld_p1  <= req_push;
        end
      end else if (req_push) begin
        if (!main_vld_p1) main_vld_p1  <= 1'b1;
        else              spill_vld_p1 <= 1'b1;
      end
      if (req_push) begin
        rr_ptr <= (win_idx == PTR_W'(NPORTS-1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  // Request payload registers; no reset, qualified by the valid flags.
  always_ff @(posedge clk) begin
    if (req_pop && spill_vld_p1) begin
      main_data_p1 <= spill_data_p1;
    end else if (req_push && (req_pop || !main_vld_p1)) begin
      main_data_p1 <= push_data;
    end
    if (req_push && main_vld_p1 && !req_pop) begin
      spill_data_p1 <= push_data;
    end
  end

  // ---------------------------------------------------------------------
  // Stage p0 (response): decode destination index and strip it from the tag
  // ---------------------------------------------------------------------
  logic [PTR_W-1:0] rsp_dst_in;
  logic [RSP_W-1:0] rsp_strip;
  logic             rsp_idx_ok;
  logic             rsp_accept;
  logic             rsp_drain;

  logic             rsp_vld_p1;
  logic [RSP_W-1:0] rsp_data_p1;
  logic [PTR_W-1:0] rsp_dst_p1;

  generate
    if (LG_N > 0) begin : g_rsp_idx
      assign rsp_dst_in = out_rsp_data[LG_N-1:0];
      assign rsp_strip  = out_rsp_data[RSP_W+LG_N-1:LG_N];
      assign rsp_idx_ok = (32'(rsp_dst_in) < 32'(NPORTS));
    end else begin : g_rsp_single
      assign rsp_dst_in = '0;
      assign rsp_strip  = out_rsp_data;
      assign rsp_idx_ok = 1'b1;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Stage p1 (response): single holding register with bypass-ready.
  // A stalled destination blocks the whole response path; responses are
  // never reordered. Out-of-range indices are consumed and dropped.
  // ---------------------------------------------------------------------
  assign rsp_drain     = rsp_vld_p1 & in_rsp_ready[rsp_dst_p1];
  assign out_rsp_ready = ~rsp_vld_p1 | in_rsp_ready[rsp_dst_p1];
  assign rsp_accept    = out_rsp_valid & out_rsp_ready;

  assign in_rsp_valid  = rsp_vld_p1 ? (NPORTS'(1) << rsp_dst_p1) : '0;
  assign in_rsp_data   = {NPORTS{rsp_data_p1}};

  // Response occupancy: a load in the same cycle as a drain keeps it full.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_vld_p1 <= 1'b0;
    end else if (rsp_accept && rsp_idx_ok) begin
      rsp_vld_p1 <= 1'b1;
    end else if (rsp_drain) begin
      rsp_vld_p1 <= 1'b0;
    end
  end

  // Response payload and destination; no reset, qualified by rsp_vld_p1.
  always_ff @(posedge clk) begin
    if (rsp_accept && rsp_idx_ok) begin
      rsp_data_p1 <= rsp_strip;
      rsp_dst_p1  <= rsp_dst_in;
    end
  end

  assign busy = main_vld_p1 | spill_vld_p1 | rsp_vld_p1;

`ifdef VX_MEM_ARB_PERF_EN
  // Free-running wrap-around counters: downstream request transfers,
  // downstream stall cycles, and responses delivered upstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_req_count    <= '0;
      perf_stall_cycles <= '0;
      perf_rsp_count    <= '0;
    end else begin
      if (req_pop)                       perf_req_count    <= perf_req_count + 64'd1;
      if (main_vld_p1 && !out_req_ready) perf_stall_cycles <= perf_stall_cycles + 64'd1;
      if (rsp_drain)                     perf_rsp_count    <= perf_rsp_count + 64'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // A response carrying an index with no matching port indicates a
  // downstream tag corruption; it is dropped in hardware.
  rsp_index_in_range: assert property (@(posedge clk) disable iff (reset)
    (out_rsp_valid && out_rsp_ready) |-> rsp_idx_ok);
`endif

endmodule

// File: tb/tb_vx_mem_port_arb.sv
// Directed testbench for vx_mem_port_arb (NPORTS=2, 4-byte beats).
module tb_vx_mem_port_arb;

  localparam int NPORTS      = 2;
  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_SIZE   = 4;
  localparam int FLAGS_WIDTH = 4;
  localparam int TAG_WIDTH   = 8;
  localparam int LG_N        = 1;
  localparam int REQ_W       = 1 + ADDR_WIDTH + DATA_SIZE*8 + DATA_SIZE + FLAGS_WIDTH + TAG_WIDTH;
  localparam int RSP_W       = DATA_SIZE*8 + TAG_WIDTH;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NPORTS-1:0]        in_req_valid;
  logic [NPORTS*REQ_W-1:0]  in_req_data;
  logic [NPORTS-1:0]        in_req_ready;
  logic [NPORTS-1:0]        in_rsp_valid;
  logic [NPORTS*RSP_W-1:0]  in_rsp_data;
  logic [NPORTS-1:0]        in_rsp_ready;
  logic                     out_req_valid;
  logic [REQ_W+LG_N-1:0]    out_req_data;
  logic                     out_req_ready;
  logic                     out_rsp_valid;
  logic [RSP_W+LG_N-1:0]    out_rsp_data;
  logic                     out_rsp_ready;
  logic                     busy;
`ifdef VX_MEM_ARB_PERF_EN
  logic [63:0]              perf_req_count;
  logic [63:0]              perf_stall_cycles;
  logic [63:0]              perf_rsp_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vx_mem_port_arb #(
    .NPORTS(NPORTS), .ADDR_WIDTH(ADDR_WIDTH), .DATA_SIZE(DATA_SIZE),
    .FLAGS_WIDTH(FLAGS_WIDTH), .TAG_WIDTH(TAG_WIDTH)
  ) dut (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_data(in_req_data), .in_req_ready(in_req_ready),
    .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_ready(in_rsp_ready),
    .out_req_valid(out_req_valid), .out_req_data(out_req_data), .out_req_ready(out_req_ready),
    .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data), .out_rsp_ready(out_rsp_ready),
    .busy(busy)
`ifdef VX_MEM_ARB_PERF_EN
    , .perf_req_count(perf_req_count), .perf_stall_cycles(perf_stall_cycles),
    .perf_rsp_count(perf_rsp_count)
`endif
  );

`ifdef VX_MEM_ARB_PERF_EN
  longint m_req, m_stall, m_rsp;
  always @(posedge clk) begin
    if (reset) begin
      m_req = 0; m_stall = 0; m_rsp = 0;
    end else begin
      if (out_req_valid && out_req_ready)  m_req++;
      if (out_req_valid && !out_req_ready) m_stall++;
      if (|(in_rsp_valid & in_rsp_ready))  m_rsp++;
    end
  end
`endif

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [REQ_W-1:0] make_req(input logic rw, input logic [31:0] addr,
      input logic [31:0] data, input logic [3:0] byteen, input logic [3:0] flags,
      input logic [7:0] tag);
    return {rw, addr, data, byteen, flags, tag};
  endfunction

  logic [REQ_W-1:0] req_a, req_p0, req_p1, req_b0, req_b1, req_c;

  initial begin
    reset = 1'b1; in_req_valid = '0; in_req_data = '0; in_rsp_ready = '0;
    out_req_ready = 1'b0; out_rsp_valid = 1'b0; out_rsp_data = '0;

    // reset state
    step(); step();
    in_req_valid = 2'b11; #1;
    check("rst_in_req_ready", in_req_ready, 2'b00);
    check("rst_out_req_valid", out_req_valid, 1'b0);
    check("rst_in_rsp_valid", in_rsp_valid, 2'b00);
    check("rst_busy", busy, 1'b0);
    in_req_valid = '0; reset = 1'b0;
    step();

    // single request from port 1
    req_a = make_req(1'b0, 32'h1000, 32'h0, 4'hF, 4'h0, 8'h5A);
    in_req_data[REQ_W +: REQ_W] = req_a;
    in_req_valid = 2'b10; out_req_ready = 1'b1; #1;
    check("single_ready", in_req_ready, 2'b10);
    step();
    in_req_valid = '0;
    check("single_valid", out_req_valid, 1'b1);
    check("single_tag", out_req_data[8:0], 9'h0B5);
    check("single_data", out_req_data, {req_a, 1'b1});
    step();
    check("single_drained", out_req_valid, 1'b0);

    // fairness: both ports valid, grants alternate starting at port 0
    req_p0 = make_req(1'b1, 32'h2000, 32'hAAAA_0000, 4'h3, 4'h1, 8'h10);
    req_p1 = make_req(1'b0, 32'h3000, 32'h5555_0000, 4'hC, 4'h2, 8'h20);
    in_req_data = {req_p1, req_p0};
    in_req_valid = 2'b11; #1;
    check("fair_ready_0", in_req_ready, 2'b01);
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("fair_valid_%0d", k), out_req_valid, 1'b1);
      check($sformatf("fair_data_%0d", k), out_req_data,
            ((k - 1) % 2 == 1) ? {req_p1, 1'b1} : {req_p0, 1'b0});
      if (k < 8) begin
        #1;
        check($sformatf("fair_ready_%0d", k), in_req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
      end
    end
    in_req_valid = '0;
    step();
    check("fair_no_extra", out_req_valid, 1'b0);

    // backpressure: two accepted (main + spill), then ready drops
    req_b0 = make_req(1'b1, 32'h4000, 32'h0BAD_0001, 4'h1, 4'h3, 8'h11);
    req_b1 = make_req(1'b1, 32'h5000, 32'h0BAD_0002, 4'h2, 4'h4, 8'h22);
    in_req_data = {req_b1, req_b0};
    out_req_ready = 1'b0; in_req_valid = 2'b11; #1;
    check("bp_ready_0", in_req_ready, 2'b01);
    step();
    check("bp_valid_1", out_req_valid, 1'b1);
    check("bp_data_1", out_req_data, {req_b0, 1'b0});
    #1;
    check("bp_ready_1", in_req_ready, 2'b10);
    step();
    check("bp_ready_full", in_req_ready, 2'b00);
    check("bp_busy", busy, 1'b1);
    check("bp_data_2", out_req_data, {req_b0, 1'b0});
    for (int k = 3; k <= 5; k++) begin
      step();
      check($sformatf("bp_stable_%0d", k), out_req_data, {req_b0, 1'b0});
      check($sformatf("bp_ready_%0d", k), in_req_ready, 2'b00);
    end
    in_req_valid = '0; out_req_ready = 1'b1;
    step();
    check("bp_drain_valid", out_req_valid, 1'b1);
    check("bp_drain_data", out_req_data, {req_b1, 1'b1});
    step();
    check("bp_empty_valid", out_req_valid, 1'b0);
    check("bp_empty_busy", busy, 1'b0);

    // response routing with a stalled destination
    out_rsp_data = {32'h0000_DEAD, 8'h5A, 1'b1};
    out_rsp_valid = 1'b1; in_rsp_ready = 2'b00; #1;
    check("rsp_ready_empty", out_rsp_ready, 1'b1);
    step();
    out_rsp_valid = 1'b0;
    check("rsp_valid", in_rsp_valid, 2'b10);
    check("rsp_data", in_rsp_data[RSP_W +: RSP_W], {32'h0000_DEAD, 8'h5A});
    check("rsp_busy", busy, 1'b1);
    check("rsp_ready_held", out_rsp_ready, 1'b0);
    for (int k = 2; k <= 3; k++) begin
      step();
      check($sformatf("rsp_hold_valid_%0d", k), in_rsp_valid, 2'b10);
      check($sformatf("rsp_hold_data_%0d", k), in_rsp_data[RSP_W +: RSP_W], {32'h0000_DEAD, 8'h5A});
      check($sformatf("rsp_hold_ready_%0d", k), out_rsp_ready, 1'b0);
    end
    in_rsp_ready = 2'b10; #1;
    check("rsp_bypass_ready", out_rsp_ready, 1'b1);
    step();
    check("rsp_drained", in_rsp_valid, 2'b00);
    check("rsp_idle_busy", busy, 1'b0);

    // back-to-back responses: load and drain in the same cycle
    in_rsp_ready = 2'b11;
    out_rsp_data = {32'h1111_2222, 8'h33, 1'b0};
    out_rsp_valid = 1'b1;
    step();
    check("b2b_valid_0", in_rsp_valid, 2'b01);
    check("b2b_data_0", in_rsp_data[0 +: RSP_W], {32'h1111_2222, 8'h33});
    out_rsp_data = {32'h3333_4444, 8'h44, 1'b1}; #1;
    check("b2b_ready", out_rsp_ready, 1'b1);
    step();
    out_rsp_valid = 1'b0;
    check("b2b_valid_1", in_rsp_valid, 2'b10);
    check("b2b_data_1", in_rsp_data[RSP_W +: RSP_W], {32'h3333_4444, 8'h44});
    step();
    check("b2b_empty", in_rsp_valid, 2'b00);

    // reset mid-flight: spill full, response held, pointer at 1
    req_c = make_req(1'b0, 32'h6000, 32'hCAFE_F00D, 4'hF, 4'h5, 8'h77);
    in_req_data[0 +: REQ_W] = req_c;
    in_req_valid = 2'b01; out_req_ready = 1'b0; in_rsp_ready = 2'b00;
    out_rsp_data = {32'h0000_BEEF, 8'h66, 1'b1}; out_rsp_valid = 1'b1;
    step();
    out_rsp_valid = 1'b0;
    check("mid_main", out_req_valid, 1'b1);
    step();
    check("mid_spill_full", in_req_ready, 2'b00);
    check("mid_busy", busy, 1'b1);
    check("mid_rsp_held", in_rsp_valid, 2'b10);
    reset = 1'b1;
    step();
    check("mid_rst_req_valid", out_req_valid, 1'b0);
    check("mid_rst_rsp_valid", in_rsp_valid, 2'b00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", in_req_ready, 2'b00);
    reset = 1'b0; in_req_valid = 2'b11; #1;
    check("mid_rst_ptr", in_req_ready, 2'b01);
    in_req_valid = '0;
    step();
    check("mid_post_valid", out_req_valid, 1'b0);

`ifdef VX_MEM_ARB_PERF_EN
    // perf counters against independently observed handshakes
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("perf_rst_req", perf_req_count, 64'd0);
    check("perf_rst_stall", perf_stall_cycles, 64'd0);
    in_req_data[0 +: REQ_W] = req_c; in_req_valid = 2'b01;
    for (int c = 0; c < 14; c++) begin
      out_req_ready = !(c == 3 || c == 4 || c == 6 || c == 7);
      step();
    end
    in_req_valid = '0; out_req_ready = 1'b1;
    step(); step(); step();
    check("perf_req", perf_req_count, 64'(m_req));
    check("perf_stall", perf_stall_cycles, 64'(m_stall));
    check("perf_rsp", perf_rsp_count, 64'(m_rsp));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
